// File: rtl/encoder83_seq.sv
// encoder83_seq: sequential 8-to-3 priority encoder with a valid/ready
// handshake on both sides. It accepts an 8-bit request vector. It then
// emits the 3-bit code of each set bit, MSB first, one beat per output
// handshake. Bit 7 maps to code 0 and bit 0 maps to code 7, which is the
// inverse of the 3-to-8 one-hot decoder mapping.
//
// Optional feature macro: ENC83_COUNT_EN adds the `count` port. This port
// reports the number of set bits in the most recently accepted vector.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   request vector on `req` is valid
//   in_ready   block can accept a vector (depends on state only)
//   req[7:0]   request vector, bit 7 -> code 0
//   out_valid  `code` is valid
//   out_ready  consumer accepts the current beat
//   code[2:0]  code of the highest-priority pending bit
//   last       current beat is the final beat of the vector
//   count[3:0] popcount of last accepted vector (ENC83_COUNT_EN only)
module encoder83_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] req,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] code,
`ifdef ENC83_COUNT_EN
    output logic [3:0] count,
`endif
    output logic       last
);

    localparam int unsigned REQ_W  = 8;
    localparam int unsigned CODE_W = 3;
`ifdef ENC83_COUNT_EN
    localparam int unsigned CNT_W  = 4;
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e              state_q;
    logic [REQ_W-1:0]    pend_q;
    logic [REQ_W-1:0]    pend_d;
    logic [CODE_W-1:0]   code_q;
    logic                last_q;
    logic                out_valid_q;
    logic                in_ready_q;
`ifdef ENC83_COUNT_EN
    logic [CNT_W-1:0]    cnt_q;
`endif

    // Code of the highest set bit; the highest index visited wins, so bit 7 gives 0.
    function automatic logic [CODE_W-1:0] msb_code(input logic [REQ_W-1:0] v);
        logic [CODE_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(REQ_W); i++) begin
            if (v[i]) begin
                c = CODE_W'(int'(REQ_W) - 1 - i);
            end
        end
        return c;
    endfunction

    // True when exactly one bit is set.
    function automatic logic is_onehot(input logic [REQ_W-1:0] v);
        return (v != '0) && ((v & (v - REQ_W'(1))) == '0);
    endfunction

`ifdef ENC83_COUNT_EN
    function automatic logic [CNT_W-1:0] popcnt(input logic [REQ_W-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(REQ_W); i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction
`endif

    // Pending vector with the bit for the current beat removed.
    always_comb begin
        pend_d = pend_q & ~(REQ_W'(8'h80) >> code_q);
    end

    // Control FSM plus registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pend_q      <= '0;
            code_q      <= '0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef ENC83_COUNT_EN
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
`ifdef ENC83_COUNT_EN
                        cnt_q <= popcnt(req);
`endif
                        // A zero vector is consumed without producing a beat.
                        if (req != '0) begin
                            state_q     <= ST_BUSY;
                            pend_q      <= req;
                            code_q      <= msb_code(req);
                            last_q      <= is_onehot(req);
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (out_valid_q && out_ready) begin
                        if (last_q) begin
                            state_q     <= ST_IDLE;
                            pend_q      <= '0;
                            code_q      <= '0;
                            last_q      <= 1'b0;
                            out_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                        end else begin
                            pend_q <= pend_d;
                            code_q <= msb_code(pend_d);
                            last_q <= is_onehot(pend_d);
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    pend_q      <= '0;
                    code_q      <= '0;
                    last_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign code      = code_q;
    assign last      = last_q;
`ifdef ENC83_COUNT_EN
    assign count     = cnt_q;
`endif

endmodule

// File: tb/tb_encoder83_seq.sv
// Self-checking bench for encoder83_seq. A reference model turns each
// accepted vector into a queue of expected beats, MSB first. Every cycle,
// the outputs are compared against the head of that queue.
module tb_encoder83_seq;

    typedef struct packed {
        logic [2:0] code;
        logic       last;
    } beat_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] req;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] code;
    logic       last;
`ifdef ENC83_COUNT_EN
    logic [3:0] count;
`endif

    beat_t exp_q[$];
    int    exp_cnt;
    int    n_checks;
    int    n_fail;
    bit    chk_on;

    encoder83_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .req       (req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .code      (code),
`ifdef ENC83_COUNT_EN
        .count     (count),
`endif
        .last      (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected beats for a vector: one per set bit, bit 7 first as code 0.
    task automatic model_accept(input logic [7:0] v);
        exp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[7 - i]) begin
                beat_t b;
                b.code = 3'(i);
                b.last = 1'b0;
                exp_q.push_back(b);
                exp_cnt++;
            end
        end
        if (exp_q.size() != 0) exp_q[exp_q.size() - 1].last = 1'b1;
    endtask

    // Outputs are compared mid-cycle; the model is then advanced for the upcoming edge.
    always @(negedge clk) begin
        if (!rst && chk_on) begin
            check_eq("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
            check_eq("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check_eq("code", 32'(code), 32'(exp_q[0].code));
                check_eq("last", 32'(last), 32'(exp_q[0].last));
            end
`ifdef ENC83_COUNT_EN
            check_eq("count", 32'(count), 32'(exp_cnt));
`endif
            if (exp_q.size() != 0) begin
                if (out_ready) void'(exp_q.pop_front());
            end else if (in_valid) begin
                model_accept(req);
            end
        end
    end

    // Present one vector and hold it until it is accepted.
    task automatic send(input logic [7:0] v);
        bit hs;
        int budget;
        hs       = 1'b0;
        budget   = 0;
        in_valid = 1'b1;
        req      = v;
        while (!hs && budget < 50) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        if (!hs) check_eq("send_timeout", 32'(hs), 32'd1);
        in_valid = 1'b0;
        req      = 8'h5A;
    endtask

    task automatic drain();
        int budget;
        budget    = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (exp_q.size() != 0 && budget < 50) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] v;
        n_checks  = 0;
        n_fail    = 0;
        exp_cnt   = 0;
        chk_on    = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        req       = 8'h00;
        #12;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_code", 32'(code), 32'd0);
        check_eq("rst_last", 32'(last), 32'd0);
`ifdef ENC83_COUNT_EN
        check_eq("rst_count", 32'(count), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_on = 1'b1;
        idle(2);

        // Single MSB request.
        out_ready = 1'b1;
        send(8'b1000_0000);
        drain();

        // Sparse pattern: codes 0, 2, 5, 7.
        send(8'b1010_0101);
        drain();

        // Stalled consumer: beat must hold for three cycles.
        out_ready = 1'b0;
        send(8'b0000_0001);
        idle(3);
        out_ready = 1'b1;
        drain();

        // Zero vector followed immediately by all-ones.
        send(8'h00);
        send(8'hFF);
        drain();

        // Asynchronous reset after the third beat of a full vector.
        out_ready = 1'b1;
        send(8'hFF);
        idle(3);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_in_ready", 32'(in_ready), 32'd1);
`ifdef ENC83_COUNT_EN
        check_eq("arst_count", 32'(count), 32'd0);
`endif
        exp_q.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);

        // Decoder round trip.
        for (int x = 0; x < 8; x++) begin
            v = 8'h80 >> x;
            send(v);
            drain();
        end

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: v = 8'h00;
                1: v = 8'h80 >> $urandom_range(0, 7);
                default: v = 8'($urandom);
            endcase
            in_valid  = 1'($urandom_range(0, 1));
            req       = v;
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
